tetris_input_ctrl: RTL and testbench
====================================

Name: tetris_input_ctrl

Overview:
- Upstream feeder for the CPU top level: turns four raw Tetris buttons into command words on write1, and a gravity tick count on write2.
- Debounces each button, then edge-detects it.
- Issues one command at a time through a sequence-numbered mailbox. The processor acknowledges a command by echoing its sequence number into register 3, which arrives here on ack_reg (outReg3).

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable clock cycles needed before a button level is accepted.
- GRAVITY_CYCLES, 1000: master-clock cycles per gravity tick; legal range 2 or more.

Ports:
- clock  in  1: master clock, the same net the CPU top level receives.
- reset  in  1: asynchronous, active-low; 0 = in reset.
- btn_left, btn_right, btn_rotate, btn_drop  in  1 each: raw, asynchronous, active-high.
- ack_reg  in  32: outReg3 from the CPU. Bits [7:0] are the acknowledged sequence number.
- write1  out  32: command mailbox into the regfile. [2:0] = command code, [15:8] = sequence number, all other bits 0.
- write2  out  32: gravity tick count into the regfile.
- cmd_pending  out  1: a command is waiting in write1 for its ack.
- drop_count  out  8: presses lost because the buffer was full; saturates at 255.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. Every register clears while reset = 0.
- Reset values: write1 = 0, write2 = 0, cmd_pending = 0, drop_count = 0, sequence counter = 0, buffer slot empty, debounce stable levels = 0, FSM = IDLE.
- Button path, per button:
  - Two-flop synchronizer.
  - Debounce counter: it increments while the synchronized level differs from the stable level, and clears when they match. When it reaches DEBOUNCE_CYCLES - 1 and the levels still differ, the stable level takes the new value and the counter clears.
  - Press pulse: one cycle, emitted on the rising edge of the stable level.
  - Latency from raw edge to press pulse: 2 + DEBOUNCE_CYCLES cycles.
- Command codes: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DROP.
- Priority when pulses coincide: DROP > ROTATE > LEFT > RIGHT.
- Sequence number:
  - Increments before each issue.
  - Wraps 255 -> 1. The value 0 is never issued, so ack_reg = 0 can never acknowledge a command.
- ack path: ack_reg[7:0] is registered one stage before the compare. The compare uses only the registered copy.
- FSM IDLE:
  - If any press pulse is present, load write1 with the highest-priority code and seq + 1, set cmd_pending, and go to PENDING.
  - Lower-priority presses in the same cycle are discarded and each one increments drop_count.
- FSM PENDING:
  - write1 is held constant.
  - A new press with the slot empty is stored in the 1-deep slot; the highest-priority press wins and any others are dropped.
  - A new press with the slot full is dropped, and drop_count increments once per press.
  - When the registered ack equals write1[15:8]:
    - Slot valid: load the slot into write1 with seq + 1, clear the slot, stay in PENDING.
    - Slot empty: clear write1[2:0] to 0 (the sequence field is retained), clear cmd_pending, go to IDLE.
  - If an ack and a new press occur in the same cycle, the ack is processed first. The press then goes into the slot if the slot is free after the ack; otherwise it is dropped.
- A stale ack (any value not equal to the current sequence) is ignored.
- Gravity:
  - Prescaler counts 0 .. GRAVITY_CYCLES-1.
  - On wrap, write2 increments by 1.
  - write2 wraps modulo 2^32 and is independent of the FSM.
- Clock domains: write1 changes only on clock edges. Because it is held until acked, the slower regfile and processor clock (clock/4) is guaranteed to sample a stable word.
- Reset mid-operation: pending command, slot and counters are lost; all outputs go to their reset values immediately (asynchronous).

Decomposition:
- Shared package holds:
  - command codes (CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_ROTATE, CMD_DROP);
  - field bounds (CODE_LSB = 0, CODE_MSB = 2, SEQ_LSB = 8, SEQ_MSB = 15);
  - FSM state encodings IDLE and PENDING.
- One sub-module, button_debounce (synchronizer + debounce counter + rising-edge pulse), instantiated four times.
- The FSM, slot, sequence counter and gravity prescaler live in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, GRAVITY_CYCLES = 10):
1. Hold btn_left high for 20 cycles, ack_reg = 0 -> press pulse 6 cycles after the edge; write1 = 0x00000101, cmd_pending = 1. It holds for 100 cycles with no ack.
2. From scenario 1, set ack_reg = 0x01 -> 2 cycles later write1 = 0x00000100 and cmd_pending = 0.
3. Pulse btn_left high for only 3 cycles (glitch) -> no press pulse; write1 unchanged; drop_count = 0.
4. btn_drop and btn_right rise together in IDLE -> write1 code = 4 (DROP); drop_count = 1.
5. While PENDING with seq = 2, press ROTATE then LEFT, then ack 0x02 -> write1 = 0x00000303 (ROTATE, seq 3); LEFT dropped; drop_count increments by 1.
6. Run 35 cycles after reset release -> write2 = 3. Pulse reset low mid-run -> write1, write2, cmd_pending and drop_count read 0 immediately. Force seq = 255, issue a command -> seq = 1.

Source files
------------

// File: rtl/tetris_input_ctrl_pkg.sv
// Shared definitions for the Tetris input controller: command codes,
// write1 field bounds, FSM states and small press-vector helpers.
// Press vectors are ordered {drop, rotate, left, right}.
package tetris_input_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DROP   = 3'd4
  } cmd_e;

  localparam int unsigned CODE_LSB = 0;
  localparam int unsigned CODE_MSB = 2;
  localparam int unsigned SEQ_LSB  = 8;
  localparam int unsigned SEQ_MSB  = 15;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  // Highest-priority command among coincident presses: DROP > ROTATE > LEFT > RIGHT.
  function automatic cmd_e pick_cmd(input logic [3:0] p);
    if (p[3])      return CMD_DROP;
    else if (p[2]) return CMD_ROTATE;
    else if (p[1]) return CMD_LEFT;
    else if (p[0]) return CMD_RIGHT;
    else           return CMD_NONE;
  endfunction

  function automatic logic [2:0] count_presses(input logic [3:0] p);
    return 3'({2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]});
  endfunction

  // Drop counter add that sticks at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] n);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_button_debounce.sv
// One button path: two-flop synchronizer, debounce counter and a one-cycle
// registered press pulse on the rising edge of the debounced level.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous active-high button
//   press      : one-cycle pulse, 2 + DEBOUNCE_CYCLES cycles after a clean raw rise
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        // Pulse in the same cycle the stable level rises so it is registered.
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller: debounces four buttons, issues one command at a time
// into the CPU regfile via a sequence-numbered mailbox and counts gravity ticks.
//   clock, reset  : master clock, asynchronous active-low reset
//   btn_*         : raw buttons
//   ack_reg       : CPU outReg3; [7:0] is the acknowledged sequence number
//   write1        : {16'b0, seq[7:0], 5'b0, code[2:0]} command mailbox
//   write2        : gravity tick count
//   cmd_pending   : write1 holds a command awaiting ack
//   drop_count    : presses lost to a full buffer, saturating
module tetris_input_ctrl
  import tetris_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GRAVITY_CYCLES  = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_drop,
  input  logic [31:0] ack_reg,
  output logic [31:0] write1,
  output logic [31:0] write2,
  output logic        cmd_pending,
  output logic [7:0]  drop_count
);

  localparam int unsigned PRE_W = $clog2(GRAVITY_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(GRAVITY_CYCLES - 1);

  logic p_left, p_right, p_rotate, p_drop;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clock), .rst_n(reset), .btn_raw(btn_left), .press(p_left)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clock), .rst_n(reset), .btn_raw(btn_right), .press(p_right)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rotate (
    .clk(clock), .rst_n(reset), .btn_raw(btn_rotate), .press(p_rotate)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_drop (
    .clk(clock), .rst_n(reset), .btn_raw(btn_drop), .press(p_drop)
  );

  state_e           state_q, state_d;
  logic [31:0]      write1_q, write1_d;
  logic [31:0]      write2_q, write2_d;
  logic             pending_q, pending_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       ack_q;
  cmd_e             slot_q, slot_d;
  logic             slot_v_q, slot_v_d;
  logic [PRE_W-1:0] pre_q, pre_d;

  logic       ack_unused;
  assign ack_unused = &{1'b0, ack_reg[31:8]};

  logic [3:0] press_vec;
  logic       any_press;
  logic [2:0] n_press;
  cmd_e       win;
  logic [7:0] seq_cur, seq_next;
  logic       ack_match;
  logic       issue_en;
  cmd_e       issue_code;
  logic       slot_free;
  logic [2:0] drop_add;

  // The sequence counter is the write1 sequence field itself; both only ever
  // change together on an issue.
  assign seq_cur   = write1_q[SEQ_MSB:SEQ_LSB];
  assign seq_next  = (seq_cur == 8'hFF) ? 8'h01 : seq_cur + 8'h01;
  assign ack_match = (ack_q == seq_cur);

  assign press_vec = {p_drop, p_rotate, p_left, p_right};
  assign any_press = |press_vec;
  assign n_press   = count_presses(press_vec);
  assign win       = pick_cmd(press_vec);

  always_comb begin
    state_d    = state_q;
    write1_d   = write1_q;
    pending_d  = pending_q;
    slot_d     = slot_q;
    slot_v_d   = slot_v_q;
    issue_en   = 1'b0;
    issue_code = CMD_NONE;
    slot_free  = 1'b0;
    drop_add   = '0;

    case (state_q)
      IDLE: begin
        // A slot can be left valid only by an ack that coincided with a press
        // while no command was buffered; it is issued ahead of newer presses.
        if (slot_v_q) begin
          issue_en   = 1'b1;
          issue_code = slot_q;
          slot_v_d   = 1'b0;
          if (any_press) begin
            slot_d   = win;
            slot_v_d = 1'b1;
            drop_add = n_press - 3'd1;
          end
        end else if (any_press) begin
          issue_en   = 1'b1;
          issue_code = win;
          drop_add   = n_press - 3'd1;
        end
      end
      PENDING: begin
        slot_free = !slot_v_q;
        if (ack_match) begin
          if (slot_v_q) begin
            issue_en   = 1'b1;
            issue_code = slot_q;
            slot_v_d   = 1'b0;
          end else begin
            write1_d[CODE_MSB:CODE_LSB] = CMD_NONE;
            pending_d = 1'b0;
            state_d   = IDLE;
          end
          slot_free = 1'b1;
        end
        if (any_press) begin
          if (slot_free) begin
            slot_d   = win;
            slot_v_d = 1'b1;
            drop_add = n_press - 3'd1;
          end else begin
            drop_add = n_press;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_en) begin
      write1_d                    = '0;
      write1_d[SEQ_MSB:SEQ_LSB]   = seq_next;
      write1_d[CODE_MSB:CODE_LSB] = issue_code;
      pending_d                   = 1'b1;
      state_d                     = PENDING;
    end

    drop_d = sat_add(drop_q, drop_add);
  end

  always_comb begin
    pre_d    = pre_q + 1'b1;
    write2_d = write2_q;
    if (pre_q == PRE_LAST) begin
      pre_d    = '0;
      write2_d = write2_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      write1_q  <= '0;
      write2_q  <= '0;
      pending_q <= 1'b0;
      drop_q    <= '0;
      ack_q     <= '0;
      slot_q    <= CMD_NONE;
      slot_v_q  <= 1'b0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      write1_q  <= write1_d;
      write2_q  <= write2_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      ack_q     <= ack_reg[7:0];
      slot_q    <= slot_d;
      slot_v_q  <= slot_v_d;
      pre_q     <= pre_d;
    end
  end

  assign write1      = write1_q;
  assign write2      = write2_q;
  assign cmd_pending = pending_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DEBOUNCE_CYCLES = 4, GRAVITY_CYCLES = 10.
module tb_tetris_input_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, btn_drop = 1'b0;
  logic [31:0] ack_reg = '0;
  logic [31:0] write1, write2;
  logic        cmd_pending;
  logic [7:0]  drop_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .GRAVITY_CYCLES (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rotate (btn_rotate),
    .btn_drop   (btn_drop),
    .ack_reg    (ack_reg),
    .write1     (write1),
    .write2     (write2),
    .cmd_pending(cmd_pending),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #12;
    check_eq("rst_write1", write1, 32'h0);
    check_eq("rst_write2", write2, 32'h0);
    check_eq("rst_pending", {31'b0, cmd_pending}, 32'h0);
    check_eq("rst_drop", {24'b0, drop_count}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step(2);

    // 1: left press, pulse 6 edges after the raw edge, issue on the 7th
    btn_left = 1'b1;
    step(6);
    check_eq("s1_before_issue", write1, 32'h0);
    step(1);
    check_eq("s1_write1", write1, 32'h0000_0101);
    check_eq("s1_pending", {31'b0, cmd_pending}, 32'h1);
    step(13);
    btn_left = 1'b0;
    step(100);
    check_eq("s1_hold_write1", write1, 32'h0000_0101);
    check_eq("s1_hold_pending", {31'b0, cmd_pending}, 32'h1);

    // 2: ack seq 1, two-edge latency
    ack_reg = 32'h1;
    step(1);
    check_eq("s2_ack_early", write1, 32'h0000_0101);
    step(1);
    check_eq("s2_write1", write1, 32'h0000_0100);
    check_eq("s2_pending", {31'b0, cmd_pending}, 32'h0);

    // 3: 3-cycle glitch is rejected
    btn_left = 1'b1;
    step(3);
    btn_left = 1'b0;
    step(12);
    check_eq("s3_write1", write1, 32'h0000_0100);
    check_eq("s3_drop", {24'b0, drop_count}, 32'h0);
    check_eq("s3_pending", {31'b0, cmd_pending}, 32'h0);

    // 4: drop and right together, drop wins, right lost
    btn_drop  = 1'b1;
    btn_right = 1'b1;
    step(7);
    check_eq("s4_write1", write1, 32'h0000_0204);
    check_eq("s4_drop", {24'b0, drop_count}, 32'h1);
    step(3);
    btn_drop  = 1'b0;
    btn_right = 1'b0;
    step(10);

    // 5: rotate buffered, left dropped, stale ack 1 ignored, ack 2 loads slot
    btn_rotate = 1'b1;
    step(7);
    btn_left = 1'b1;
    step(7);
    check_eq("s5_stale_ack", write1, 32'h0000_0204);
    check_eq("s5_drop_full", {24'b0, drop_count}, 32'h2);
    ack_reg = 32'h2;
    step(2);
    check_eq("s5_write1", write1, 32'h0000_0303);
    check_eq("s5_pending", {31'b0, cmd_pending}, 32'h1);
    check_eq("s5_drop", {24'b0, drop_count}, 32'h2);
    btn_rotate = 1'b0;
    btn_left   = 1'b0;
    step(10);
    ack_reg = 32'h3;
    step(2);
    check_eq("s5_idle_write1", write1, 32'h0000_0300);
    check_eq("s5_idle_pending", {31'b0, cmd_pending}, 32'h0);

    // 6: asynchronous reset mid-run, then gravity count
    btn_left = 1'b1;
    step(7);
    reset = 1'b0;
    #1;
    check_eq("s6_rst_write1", write1, 32'h0);
    check_eq("s6_rst_write2", write2, 32'h0);
    check_eq("s6_rst_pending", {31'b0, cmd_pending}, 32'h0);
    check_eq("s6_rst_drop", {24'b0, drop_count}, 32'h0);
    btn_left = 1'b0;
    ack_reg  = '0;
    @(negedge clock);
    reset = 1'b1;
    step(35);
    check_eq("s6_gravity", write2, 32'h3);

    // 6b: 255 issue/ack rounds, then the next issue wraps to seq 1
    for (int i = 1; i <= 255; i++) begin
      btn_left = 1'b1;
      step(7);
      btn_left = 1'b0;
      step(7);
      ack_reg = 32'(i);
      step(2);
    end
    check_eq("s6_seq255", write1, 32'h0000_FF00);
    btn_left = 1'b1;
    step(7);
    check_eq("s6_seq_wrap", write1, 32'h0000_0101);
    check_eq("s6_wrap_drop", {24'b0, drop_count}, 32'h0);
    btn_left = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
